// File: rtl/ex_multiplier_if.sv
// Issue-side bundle for the execute-stage multiplier: operand request plus
// result/flag response. master = issue logic, slave = multiplier.
interface ex_multiplier_if;
   logic        start_i;
   logic        signed_i;
   logic [31:0] a_i;
   logic [31:0] b_i;
   logic        busy_o;
   logic        done_o;
   logic [31:0] result_lo_o;
   logic [31:0] result_hi_o;
   logic [5:0]  flag_o;
   logic        flag_write_o;

   modport master (
      output start_i, signed_i, a_i, b_i,
      input  busy_o, done_o, result_lo_o, result_hi_o, flag_o, flag_write_o
   );

   modport slave (
      input  start_i, signed_i, a_i, b_i,
      output busy_o, done_o, result_lo_o, result_hi_o, flag_o, flag_write_o
   );
endinterface

// File: rtl/ex_multiplier.sv
// Iterative 32x32 shift-add multiplier with flag generation.
// Optional macro EX_MUL_EARLY_TERM_EN: leave RUN once the multiplier register empties.
module ex_multiplier (
   input logic            clk,
   input logic            rst,
   ex_multiplier_if.slave bus
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t      state, state_nxt;
   logic [63:0] mcand, acc, acc_nxt, prod;
   logic [31:0] mplr, mplr_nxt, a_mag, b_mag;
   logic [31:0] res_lo, res_hi;
   logic [5:0]  cnt, flags, flags_nxt;
   logic        sgn, neg, last, carry;

   // Magnitudes stay unsigned 32-bit, so -2^31 maps to 0x80000000 exactly.
   assign a_mag = (bus.signed_i && bus.a_i[31]) ? (~bus.a_i + 32'd1) : bus.a_i;
   assign b_mag = (bus.signed_i && bus.b_i[31]) ? (~bus.b_i + 32'd1) : bus.b_i;

   always_comb begin
      acc_nxt  = mplr[0] ? (acc + mcand) : acc;
      mplr_nxt = mplr >> 1;
`ifdef EX_MUL_EARLY_TERM_EN
      last     = (cnt == 6'd31) || (mplr_nxt == 32'd0);
`else
      last     = (cnt == 6'd31);
`endif
      prod      = neg ? (~acc_nxt + 64'd1) : acc_nxt;
      carry     = sgn ? (prod[63:32] != {32{prod[31]}}) : (prod[63:32] != 32'd0);
      flags_nxt = {1'b0, ~^prod[7:0], carry, carry, sgn & prod[63], prod == 64'd0};
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.start_i) state_nxt = RUN;
         RUN:     if (last) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Results are captured on the last RUN edge so they are already valid
   // in the DONE cycle, alongside done_o.
   always_ff @(posedge clk) begin
      if (rst) begin
         mcand  <= 64'd0;
         acc    <= 64'd0;
         mplr   <= 32'd0;
         cnt    <= 6'd0;
         sgn    <= 1'b0;
         neg    <= 1'b0;
         res_lo <= 32'd0;
         res_hi <= 32'd0;
         flags  <= 6'd0;
      end else begin
         case (state)
            IDLE: if (bus.start_i) begin
               mcand <= {32'd0, a_mag};
               mplr  <= b_mag;
               acc   <= 64'd0;
               cnt   <= 6'd0;
               sgn   <= bus.signed_i;
               neg   <= bus.signed_i & (bus.a_i[31] ^ bus.b_i[31]);
            end
            RUN: begin
               acc   <= acc_nxt;
               mcand <= mcand << 1;
               mplr  <= mplr_nxt;
               cnt   <= cnt + 6'd1;
               if (last) begin
                  res_lo <= prod[31:0];
                  res_hi <= prod[63:32];
                  flags  <= flags_nxt;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.busy_o       = (state != IDLE);
   assign bus.done_o       = (state == DONE);
   assign bus.flag_write_o = (state == DONE);
   assign bus.result_lo_o  = res_lo;
   assign bus.result_hi_o  = res_hi;
   assign bus.flag_o       = flags;
endmodule

// File: tb/tb_ex_multiplier.sv
// Scoreboard bench for ex_multiplier: expected product/flags/latency queued at issue,
// popped and compared when done_o fires.
module tb_ex_multiplier;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   ex_multiplier_if bus();
   ex_multiplier dut (.clk(clk), .rst(rst), .bus(bus));

   typedef struct packed {
      logic [31:0] hi;
      logic [31:0] lo;
      logic [5:0]  flag;
      int          lat;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   logic [31:0] d_a  [5] = '{32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'h12345678, 32'h80000000};
   logic [31:0] d_b  [5] = '{32'd6, 32'd5,        32'hFFFFFFFF, 32'h00000000, 32'h80000000};
   bit          d_s  [5] = '{1'b0,  1'b1,         1'b0,         1'b0,         1'b1};
   logic [31:0] d_hi [5] = '{32'h0, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h0,        32'h40000000};
   logic [31:0] d_lo [5] = '{32'h2A, 32'hFFFFFFF1, 32'h1,       32'h0,        32'h0};
   logic [5:0]  d_fl [5] = '{6'b000000, 6'b000010, 6'b001100, 6'b010001, 6'b011100};

   // done_o cycle relative to the accepting edge
   function automatic int exp_lat(logic [31:0] b, bit s);
      int n;
      logic [31:0] m;
      m = (s && b[31]) ? (~b + 32'd1) : b;
      n = 32;
`ifdef EX_MUL_EARLY_TERM_EN
      n = 1;
      for (int i = 0; i < 32; i++) if (m[i]) n = i + 1;
`endif
      if (m === 32'hx) n = 0;
      return n + 1;
   endfunction

   function automatic exp_t model(logic [31:0] a, logic [31:0] b, bit s);
      logic [63:0] x, y, p;
      logic        c;
      exp_t        e;
      x = s ? {{32{a[31]}}, a} : {32'd0, a};
      y = s ? {{32{b[31]}}, b} : {32'd0, b};
      p = x * y;
      e.hi = p[63:32];
      e.lo = p[31:0];
      c = s ? (e.hi != {32{e.lo[31]}}) : (e.hi != 32'd0);
      e.flag = {1'b0, ~^e.lo[7:0], c, c, s & p[63], p == 64'd0};
      e.lat = exp_lat(b, s);
      return e;
   endfunction

   // Called at a negedge in IDLE; returns at the negedge of cycle T+1.
   task automatic issue(input logic [31:0] a, input logic [31:0] b, input bit s, input exp_t e);
      sb.push_back(e);
      bus.start_i = 1'b1; bus.a_i = a; bus.b_i = b; bus.signed_i = s;
      @(negedge clk);
      bus.start_i = 1'b0; bus.a_i = $urandom; bus.b_i = $urandom;
      bus.signed_i = 1'($urandom_range(0, 1));
   endtask

   // Waits for done_o, pops the scoreboard and compares. inj>0 pulses a stray
   // start at cycle T+inj and again in the done_o cycle.
   task automatic collect(input string nm, input int inj);
      exp_t e;
      int   lat;
      bit   to;
      logic [31:0] hi, lo;
      e = sb.pop_front();
      checks++;
      if (bus.busy_o !== 1'b1) begin
         errors++; $display("FAIL %s busy_after_start got %b want 1", nm, bus.busy_o);
      end
      lat = 1; to = 1'b1;
      while (lat <= 40) begin
         if (bus.done_o === 1'b1) begin to = 1'b0; break; end
         bus.start_i = (lat == inj); bus.a_i = 32'h55; bus.b_i = 32'h3; bus.signed_i = 1'b1;
         @(negedge clk);
         lat++;
      end
      checks++;
      if (to) begin
         bus.start_i = 1'b0;
         errors++; $display("FAIL %s timeout no done_o within 40 cycles", nm);
         return;
      end
      checks++;
      if (lat !== e.lat) begin errors++; $display("FAIL %s latency got %0d want %0d", nm, lat, e.lat); end
      checks++;
      if (bus.result_hi_o !== e.hi) begin errors++; $display("FAIL %s result_hi got %h want %h", nm, bus.result_hi_o, e.hi); end
      checks++;
      if (bus.result_lo_o !== e.lo) begin errors++; $display("FAIL %s result_lo got %h want %h", nm, bus.result_lo_o, e.lo); end
      checks++;
      if (bus.flag_o !== e.flag) begin errors++; $display("FAIL %s flag got %b want %b", nm, bus.flag_o, e.flag); end
      checks++;
      if ({bus.flag_write_o, bus.busy_o} !== 2'b11) begin
         errors++; $display("FAIL %s done_cycle flag_write/busy got %b want 11", nm, {bus.flag_write_o, bus.busy_o});
      end
      hi = bus.result_hi_o; lo = bus.result_lo_o;
      bus.start_i = (inj > 0);
      @(negedge clk);
      bus.start_i = 1'b0;
      checks++;
      if ({bus.done_o, bus.flag_write_o, bus.busy_o} !== 3'b000) begin
         errors++; $display("FAIL %s after_done done/fw/busy got %b want 000", nm, {bus.done_o, bus.flag_write_o, bus.busy_o});
      end
      checks++;
      if ({bus.result_hi_o, bus.result_lo_o} !== {hi, lo}) begin
         errors++; $display("FAIL %s hold got %h want %h", nm, {bus.result_hi_o, bus.result_lo_o}, {hi, lo});
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.start_i = 1'b1; bus.a_i = 32'd9; bus.b_i = 32'd9; bus.signed_i = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({bus.busy_o, bus.done_o, bus.flag_write_o, bus.result_hi_o, bus.result_lo_o, bus.flag_o} !== 73'd0) begin
         errors++; $display("FAIL reset_values got busy=%b done=%b fw=%b hi=%h lo=%h flag=%b want all 0",
                            bus.busy_o, bus.done_o, bus.flag_write_o, bus.result_hi_o, bus.result_lo_o, bus.flag_o);
      end
      rst = 1'b0; bus.start_i = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL reset_dominates_start busy got %b want 0", bus.busy_o); end
   endtask

   task automatic test_directed();
      exp_t e;
      for (int i = 0; i < 5; i++) begin
         e.hi = d_hi[i]; e.lo = d_lo[i]; e.flag = d_fl[i]; e.lat = exp_lat(d_b[i], d_s[i]);
         issue(d_a[i], d_b[i], d_s[i], e);
         collect($sformatf("directed%0d", i), 0);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] a, b;
      bit s;
      for (int i = 0; i < 10; i++) begin
         a = $urandom; b = $urandom >> $urandom_range(0, 31); s = 1'($urandom_range(0, 1));
         issue(a, b, s, model(a, b, s));
         collect($sformatf("b2b%0d", i), 0);
      end
   endtask

   task automatic test_ignored_start();
      int extra = 0;
      issue(32'd7, 32'd6, 1'b0, model(32'd7, 32'd6, 1'b0));
      collect("ignored_start", 5);
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (bus.done_o === 1'b1 || bus.busy_o === 1'b1) extra++;
      end
      checks++;
      if (extra !== 0) begin errors++; $display("FAIL ignored_start extra_activity got %0d want 0", extra); end
   endtask

   task automatic test_reset_abort();
      exp_t e;
      int fw = 0;
      issue(32'hFFFFFFFF, 32'd3, 1'b0, model(32'hFFFFFFFF, 32'd3, 1'b0));
      e = sb.pop_front();
      repeat (9) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if ({bus.busy_o, bus.done_o, bus.flag_write_o, bus.result_hi_o, bus.result_lo_o, bus.flag_o} !== 73'd0) begin
         errors++; $display("FAIL abort_outputs got busy=%b done=%b fw=%b hi=%h lo=%h flag=%b want all 0",
                            bus.busy_o, bus.done_o, bus.flag_write_o, bus.result_hi_o, bus.result_lo_o, bus.flag_o);
      end
      for (int i = 0; i < 40; i++) begin
         if (bus.flag_write_o === 1'b1) fw++;
         @(negedge clk);
      end
      checks++;
      if (fw !== 0) begin errors++; $display("FAIL abort_flag_write got %0d pulses want 0 (dropped %h)", fw, e.lo); end
      issue(32'hFFFFFFF0, 32'h00001000, 1'b1, model(32'hFFFFFFF0, 32'h00001000, 1'b1));
      collect("after_abort", 0);
   endtask

   initial begin
      #600000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      bus.start_i = 1'b0; bus.signed_i = 1'b0; bus.a_i = 32'd0; bus.b_i = 32'd0;
      @(negedge clk);
      test_reset();
      test_directed();
      test_back_to_back();
      test_ignored_start();
      test_reset_abort();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/ex_multiplier.md
# ex_multiplier

Iterative 32x32 shift-add multiplier in the execute stage. It accepts one operand pair per start pulse and produces a 64-bit product split into high and low words. It also produces a 6-bit flag vector with a one-cycle flag-write strobe, which feeds the flag register's `data_i`/`write` inputs directly. One multiply is in flight at a time; the issue logic stalls on `busy_o`.

## Interface
Parameters:
- none

Ports:
- `clk` input 1: clock; all state updates on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start_i` input 1: request a multiply; only accepted in IDLE.
- `signed_i` input 1: 1 = two's-complement operands, 0 = unsigned; sampled with `start_i`.
- `a_i` input 32: multiplicand; sampled with `start_i`.
- `b_i` input 32: multiplier; sampled with `start_i`.
- `busy_o` output 1: high in RUN and DONE.
- `done_o` output 1: one-cycle pulse; results valid from this cycle.
- `result_lo_o` output 32: product[31:0].
- `result_hi_o` output 32: product[63:32].
- `flag_o` output 6: flag vector, bit order defined below.
- `flag_write_o` output 1: equal to `done_o`; drives the flag register write.

## Operation
- FSM states: IDLE, RUN, DONE.
- **IDLE**
  - With `start_i`=1 at an edge: latch the sign flag and operand magnitudes (negate `a_i`/`b_i` if `signed_i` and the MSB is set).
  - Load a 64-bit multiplicand register, a 32-bit multiplier register and a 64-bit accumulator of 0.
  - Set iteration count 0 and go to RUN.
- **RUN**, one iteration per cycle:
  - If multiplier[0]=1, add the multiplicand to the accumulator.
  - Shift the multiplicand left 1 and the multiplier right 1 (logical); count +1.
  - Go to DONE when count reaches 32 (see Configuration for the early exit).
- **DONE**, one cycle:
  - Product = accumulator, negated in 64 bits if signed mode and the operand signs differ.
  - Register results and flags; assert `done_o`/`flag_write_o`; go to IDLE.
- Results and flags hold their values until the next DONE or `rst`.
- Flags, computed on the final product:
  - [0] Z: 64-bit product == 0.
  - [1] N: product[63] in signed mode, else 0.
  - [2] C: high word significant. Unsigned: `result_hi` != 0. Signed: `result_hi` != {32{`result_lo`[31]}}.
  - [3] V: same value as C.
  - [4] P: 1 when `result_lo`[7:0] has an even number of ones.
  - [5]: reserved, always 0.
- `start_i` while `busy_o`=1 is ignored; it is not queued.
- A `start_i` in the same cycle as `done_o` is also ignored, because the FSM is not yet in IDLE.
- Arithmetic is modulo 2^64. Signed -2^31 x -2^31 = 2^62 is exact, because magnitudes are held unsigned in 32 bits.

## Timing
- Start accepted at edge T: RUN occupies cycles T+1 .. T+n, and `done_o` is high during cycle T+n+1.
- Without early exit, n = 32: `done_o` in cycle T+33, fixed latency.
- `busy_o` is high from cycle T+1 through the `done_o` cycle inclusive; it is low in the cycle after `done_o`.
- The earliest next accepted start is the cycle after `done_o`.
- Reset values:
  - State IDLE.
  - `busy_o`, `done_o`, `flag_write_o` = 0.
  - `result_lo_o`, `result_hi_o` = 0.
  - `flag_o` = 6'b000000.
- `rst` mid-operation (RUN or DONE) aborts at that edge:
  - No `done_o`/`flag_write_o` pulse is produced.
  - All outputs return to their reset values.
- `rst` dominates `start_i` in the same cycle.

## Configuration
- Macro `EX_MUL_EARLY_TERM_EN`.
- Defined: RUN also exits to DONE when the shifted multiplier register becomes 0.
  - n = max(1, index of the highest set bit of |b| + 1).
  - Examples: b=0 or b=1 gives done at T+2; |b|=0x80000000 gives T+33.
  - Results are identical to the undefined case.
- Undefined: always 32 RUN cycles, fixed latency of 33 cycles.

## Test plan
- Unsigned 7 x 6 → `result_hi`=0x00000000, `result_lo`=0x0000002A, `flag_o`=6'b000000, single `done_o` at T+33. With `EX_MUL_EARLY_TERM_EN`, `done_o` at T+4.
- Signed -3 x 5 → `result_hi`=0xFFFFFFFF, `result_lo`=0xFFFFFFF1, N=1, Z=C=V=P=0.
- Unsigned 0xFFFFFFFF x 0xFFFFFFFF → `result_hi`=0xFFFFFFFE, `result_lo`=0x00000001, C=V=1, Z=N=0, P=0.
- 0x12345678 x 0 → product 0, Z=1, P=1. With `EX_MUL_EARLY_TERM_EN`, `done_o` at T+2; otherwise at T+33.
- `start_i` with new operands pulsed at T+5 and at the `done_o` cycle of a running multiply → both ignored: exactly one `done_o`, and the results match the first operands.
- `rst` asserted at T+10 of a running multiply → all outputs 0 from the next cycle, no `flag_write_o`. A new start after reset completes normally.
